// File: rtl/serial_frame_pkg.sv
// Shared types and default constants for the serial frame receiver.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int         DEFAULT_SYNC_W       = 8;
  localparam logic [7:0] DEFAULT_SYNC_PATTERN = 8'hA5;
  localparam int         DEFAULT_DATA_W       = 8;
  localparam bit         DEFAULT_PARITY_EN    = 1'b1;

endpackage

// File: rtl/sync_matcher.sv
// Sync hunter: MSB-first shift register, fill counter and pattern comparator.
// match_o is combinational and includes the bit being accepted this cycle.
module sync_matcher
  import serial_frame_pkg::*;
#(
  parameter int                SYNC_W       = DEFAULT_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(DEFAULT_SYNC_PATTERN)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic bit_i,
  input  logic accept_i,
  input  logic clear_i,
  output logic match_o
);

  localparam int FILL_W = $clog2(SYNC_W + 1);

  logic [SYNC_W-1:0] shift_q, shift_d, shiftNext;
  logic [FILL_W-1:0] fill_q, fill_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_q <= '0;
      fill_q  <= '0;
    end else begin
      shift_q <= shift_d;
      fill_q  <= fill_d;
    end
  end

  // Fill saturates at SYNC_W; a match needs SYNC_W-1 prior bits plus the current one.
  always_comb begin
    shiftNext = (shift_q << 1) | SYNC_W'(bit_i);
    shift_d   = shift_q;
    fill_d    = fill_q;
    if (clear_i) begin
      shift_d = '0;
      fill_d  = '0;
    end else if (accept_i) begin
      shift_d = shiftNext;
      if (fill_q < FILL_W'(SYNC_W)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
    match_o = accept_i && (fill_q >= FILL_W'(SYNC_W - 1)) && (shiftNext == SYNC_PATTERN);
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts a sync word, deserializes a payload, checks
// optional even parity and reports each frame with a one-cycle strobe.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int                SYNC_W       = DEFAULT_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(DEFAULT_SYNC_PATTERN),
  parameter int                DATA_W       = DEFAULT_DATA_W,
  parameter bit                PARITY_EN    = DEFAULT_PARITY_EN
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              data_i,
  input  logic              en_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_valid_o,
  output logic              parity_err_o,
  output logic              in_frame_o,
  output logic [7:0]        frame_cnt_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0] payload_q, payload_d, payloadNext;
  logic              parityAcc_q, parityAcc_d;
  logic [DATA_W-1:0] word_q, word_d, completeWord;
  logic              wordValid_q, wordValid_d;
  logic              parityErr_q, parityErr_d;
  logic              inFrame_q, inFrame_d;
  logic [7:0]        frameCnt_q, frameCnt_d;
  logic              syncMatch, complete, frameErr;

  sync_matcher #(
    .SYNC_W       (SYNC_W),
    .SYNC_PATTERN (SYNC_PATTERN)
  ) uSyncMatcher (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .bit_i    (data_i),
    .accept_i (en_i && (state_q == HUNT)),
    .clear_i  (syncMatch),
    .match_o  (syncMatch)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= HUNT;
      bitCnt_q    <= '0;
      payload_q   <= '0;
      parityAcc_q <= 1'b0;
      word_q      <= '0;
      wordValid_q <= 1'b0;
      parityErr_q <= 1'b0;
      inFrame_q   <= 1'b0;
      frameCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      payload_q   <= payload_d;
      parityAcc_q <= parityAcc_d;
      word_q      <= word_d;
      wordValid_q <= wordValid_d;
      parityErr_q <= parityErr_d;
      inFrame_q   <= inFrame_d;
      frameCnt_q  <= frameCnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    payload_d    = payload_q;
    parityAcc_d  = parityAcc_q;
    word_d       = word_q;
    wordValid_d  = 1'b0;
    parityErr_d  = 1'b0;
    frameCnt_d   = frameCnt_q;
    complete     = 1'b0;
    frameErr     = 1'b0;
    payloadNext  = (payload_q << 1) | DATA_W'(data_i);
    completeWord = payload_q;

    unique case (state_q)
      HUNT: begin
        if (syncMatch) begin
          state_d     = DATA;
          bitCnt_d    = '0;
          payload_d   = '0;
          parityAcc_d = 1'b0;
        end
      end
      DATA: begin
        if (en_i) begin
          payload_d   = payloadNext;
          parityAcc_d = parityAcc_q ^ data_i;
          bitCnt_d    = bitCnt_q + CNT_W'(1);
          if (bitCnt_q == CNT_W'(DATA_W - 1)) begin
            if (PARITY_EN) begin
              state_d = PARITY;
            end else begin
              complete     = 1'b1;
              completeWord = payloadNext;
            end
          end
        end
      end
      PARITY: begin
        if (en_i) begin
          complete = 1'b1;
          frameErr = parityAcc_q ^ data_i;
        end
      end
      default: state_d = HUNT;
    endcase

    // Completion always drops back to HUNT; the matcher was cleared on sync.
    if (complete) begin
      state_d     = HUNT;
      word_d      = completeWord;
      wordValid_d = 1'b1;
      parityErr_d = frameErr;
      if (!frameErr) begin
        frameCnt_d = frameCnt_q + 8'd1;
      end
    end

    inFrame_d = (state_d != HUNT);
  end

  assign word_o       = word_q;
  assign word_valid_o = wordValid_q;
  assign parity_err_o = parityErr_q;
  assign in_frame_o   = inFrame_q;
  assign frame_cnt_o  = frameCnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: table of frames plus hand-written
// corner sequences, with a scoreboard queue checked on every word_valid strobe.
module tb_serial_frame_rx;

  logic       clk_i;
  logic       reset_i;
  logic       data_i;
  logic       en_i;
  logic [7:0] word_o;
  logic       word_valid_o;
  logic       parity_err_o;
  logic       in_frame_o;
  logic [7:0] frame_cnt_o;

  typedef struct {
    logic [7:0] sync;
    logic [7:0] payload;
    logic       par;
    bit         gaps;
    logic [7:0] expWord;
    logic       expErr;
    logic [7:0] expCnt;
  } vec_t;

  typedef struct {
    logic [7:0] word;
    logic       err;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] expCnt;
  logic [7:0] expWordHeld;
  int         compared;
  int         mismatched;
  vec_t       vecs[5];

  serial_frame_rx dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .data_i       (data_i),
    .en_i         (en_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .parity_err_o (parity_err_o),
    .in_frame_o   (in_frame_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One accepted bit per call; an optional en=0 cycle with inverted data precedes it.
  task automatic sendBit(input logic b, input bit gap);
    if (gap) begin
      en_i   = 1'b0;
      data_i = ~b;
      @(posedge clk_i);
      #1;
    end
    en_i   = 1'b1;
    data_i = b;
    @(posedge clk_i);
    #1;
    en_i   = 1'b0;
    data_i = $urandom_range(0, 1);
  endtask

  task automatic doReset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    en_i    = 1'b1;
    data_i  = 1'b1;
    expQ.delete();
    expCnt      = 8'd0;
    expWordHeld = 8'd0;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    en_i    = 1'b0;
    checkOutput("rst_word", word_o, 0);
    checkOutput("rst_valid", word_valid_o, 0);
    checkOutput("rst_perr", parity_err_o, 0);
    checkOutput("rst_in_frame", in_frame_o, 0);
    checkOutput("rst_frame_cnt", frame_cnt_o, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      sendBit(v.sync[7-i], v.gaps);
      if (i == 6) checkOutput("in_frame_before_last_sync", in_frame_o, 0);
    end
    checkOutput("in_frame_after_sync", in_frame_o, 1);
    for (int i = 0; i < 8; i++) begin
      sendBit(v.payload[7-i], v.gaps);
      checkOutput("no_early_strobe", word_valid_o, 0);
    end
    checkOutput("in_frame_in_parity", in_frame_o, 1);
    e.word = v.expWord;
    e.err  = v.expErr;
    expQ.push_back(e);
    sendBit(v.par, v.gaps);
    checkOutput("strobe_latency", word_valid_o, 1);
    checkOutput("in_frame_fall", in_frame_o, 0);
    checkOutput("frame_cnt_vec", frame_cnt_o, {24'd0, v.expCnt});
  endtask

  // Scoreboard monitor: pops on each strobe, otherwise checks held outputs.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (word_valid_o) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_strobe", word_valid_o, 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          if (!e.err) expCnt = expCnt + 8'd1;
          expWordHeld = e.word;
          checkOutput("sb_word", word_o, {24'd0, e.word});
          checkOutput("sb_parity_err", parity_err_o, {31'd0, e.err});
          checkOutput("sb_frame_cnt", frame_cnt_o, {24'd0, expCnt});
        end
      end else begin
        checkOutput("perr_idle", parity_err_o, 0);
        checkOutput("word_hold", word_o, {24'd0, expWordHeld});
        checkOutput("cnt_hold", frame_cnt_o, {24'd0, expCnt});
      end
    end
  end

  initial begin
    vec_t v;
    compared    = 0;
    mismatched  = 0;
    expCnt      = 8'd0;
    expWordHeld = 8'd0;
    reset_i     = 1'b1;
    en_i        = 1'b0;
    data_i      = 1'b0;

    vecs[0] = '{sync: 8'hA5, payload: 8'h3C, par: 1'b0, gaps: 1'b0, expWord: 8'h3C, expErr: 1'b0, expCnt: 8'd1};
    vecs[1] = '{sync: 8'hA5, payload: 8'h3C, par: 1'b1, gaps: 1'b0, expWord: 8'h3C, expErr: 1'b1, expCnt: 8'd1};
    vecs[2] = '{sync: 8'hA5, payload: 8'hA5, par: 1'b0, gaps: 1'b0, expWord: 8'hA5, expErr: 1'b0, expCnt: 8'd2};
    vecs[3] = '{sync: 8'hA5, payload: 8'h01, par: 1'b1, gaps: 1'b0, expWord: 8'h01, expErr: 1'b0, expCnt: 8'd3};
    vecs[4] = '{sync: 8'hA5, payload: 8'h3C, par: 1'b0, gaps: 1'b1, expWord: 8'h3C, expErr: 1'b0, expCnt: 8'd4};

    doReset();
    $display("[TB] table-driven frames");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
    end

    // Seven bits that would complete A5 against a stale shift register.
    $display("[TB] stale sync seed sequence");
    begin
      logic [6:0] seed;
      seed = 7'b0100101;
      for (int i = 6; i >= 0; i--) begin
        sendBit(seed[i], 1'b0);
        checkOutput("seed_no_sync", in_frame_o, 0);
      end
    end
    v = '{sync: 8'hA5, payload: 8'h5A, par: 1'b0, gaps: 1'b0, expWord: 8'h5A, expErr: 1'b0, expCnt: 8'd5};
    applyStimulus(v);

    $display("[TB] reset mid-frame");
    doReset();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] s;
      s = 8'hA5;
      sendBit(s[i], 1'b0);
    end
    for (int i = 7; i >= 4; i--) begin
      logic [7:0] p;
      p = 8'h3C;
      sendBit(p[i], 1'b0);
    end
    checkOutput("abort_in_frame", in_frame_o, 1);
    doReset();
    v = '{sync: 8'hA5, payload: 8'h3C, par: 1'b0, gaps: 1'b0, expWord: 8'h3C, expErr: 1'b0, expCnt: 8'd1};
    applyStimulus(v);

    $display("[TB] frame counter wrap");
    doReset();
    for (int i = 0; i < 257; i++) begin
      v = '{sync: 8'hA5, payload: 8'h3C, par: 1'b0, gaps: 1'b0, expWord: 8'h3C, expErr: 1'b0,
            expCnt: 8'((i + 1) % 256)};
      applyStimulus(v);
    end

    repeat (4) @(posedge clk_i);
    #1;
    checkOutput("scoreboard_drained", expQ.size(), 0);
    checkOutput("final_frame_cnt", frame_cnt_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial frame receiver that sits directly downstream of the single-bit D flip-flop stage and consumes its registered output `q` as a serial bit stream. It hunts for a fixed sync pattern, then deserializes a fixed-width payload word and checks an optional even-parity bit. It delivers each word with a one-cycle valid strobe, a parity-error flag and a good-frame counter.

## Interface
Parameters:
- `SYNC_W`, 8: sync pattern width in bits.
- `SYNC_PATTERN`, 8'hA5: sync pattern, MSB received first.
- `DATA_W`, 8: payload width in bits.
- `PARITY_EN`, 1: 1 = one even-parity bit follows the payload; 0 = no parity bit.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `data` in 1: serial input bit, driven by the upstream flip-flop's `q`.
- `en` in 1: bit-accept qualifier; `data` is consumed only on edges where `en`=1.
- `word` out DATA_W: last received payload, MSB first on the wire.
- `word_valid` out 1: one-cycle strobe when a frame completes.
- `parity_err` out 1: valid only with `word_valid`; 1 = parity mismatch.
- `in_frame` out 1: 1 while in DATA or PARITY state.
- `frame_cnt` out 8: count of good (parity-correct) frames.

## Operation
- States:
  - HUNT:
    - Each accepted bit shifts into a SYNC_W-bit shift register, MSB first.
    - A fill counter tracks accepted bits since entering HUNT.
    - Match occurs when fill ≥ SYNC_W and (shift register including the current bit) == SYNC_PATTERN. On match, go to DATA and clear the bit counter.
  - DATA:
    - Accepted bits shift into the payload register, MSB first.
    - When the DATA_W-th bit is accepted, go to PARITY if PARITY_EN=1, else complete the frame.
    - Sync patterns inside the payload are ignored.
  - PARITY:
    - The next accepted bit is the parity bit.
    - The frame is good when the XOR of (payload bits and parity bit) is 0. Then complete the frame.
- Frame completion:
  - Load `word`, pulse `word_valid`, set `parity_err`.
  - On a good frame, increment `frame_cnt`.
  - Return to HUNT with the fill counter cleared, so the next frame needs a full fresh sync pattern. Trailing payload bits never seed sync.
- `en`=0: state, counters and registers hold; the edge consumes no bit.
- `frame_cnt` wraps 255→0. Errored frames still update `word`.
- `word` holds its value until the next completion.

## Timing
- Reset values:
  - State = HUNT; fill counter, bit counter and shift registers = 0.
  - `word`=0, `word_valid`=0, `parity_err`=0, `in_frame`=0, `frame_cnt`=0.
- All outputs are registered.
- `word_valid` is high for exactly the one cycle after the edge that accepted the final bit (parity bit, or last payload bit when PARITY_EN=0). `parity_err` is 0 whenever `word_valid`=0.
- `in_frame` rises the cycle after the edge that accepted the last sync bit. It falls in the same cycle that `word_valid` rises.
- Minimum frame length: SYNC_W+DATA_W+PARITY_EN accepted bits. Back-to-back frames need no gap bits.
- Reset asserted mid-frame: the partial frame is discarded, the next cycle shows reset values, and no `word_valid` is issued.
- Reset has priority over `en`.

## Structure
- Shared package `serial_frame_pkg`:
  - State enum (HUNT, DATA, PARITY).
  - Default constants SYNC_W, SYNC_PATTERN, DATA_W.
- Sub-module `sync_matcher`:
  - Contents: shift register plus fill counter plus comparator.
  - Inputs: bit, accept, clear.
  - Output: match.
  - Instantiated once. The FSM, payload shifter, parity accumulator and counter stay in the top.

## Test plan
- Defaults, `en`=1. Send 1010_0101, 0011_1100, parity 0 → `word`=8'h3C, `word_valid` high one cycle, `parity_err`=0, `frame_cnt`=1.
- Same frame with parity 1 → `word`=8'h3C, `word_valid` with `parity_err`=1, `frame_cnt` stays 0.
- Good frame with payload 8'hA5 (parity 0), followed immediately by a second sync and payload 8'h01 (parity 1) → two valid strobes, with `word`=8'hA5 then 8'h01. The payload A5 is not taken as sync. `frame_cnt`=2.
- Good frame with `en` toggled 0/1 every cycle → same result as the first scenario, with the `word_valid` strobe delayed accordingly. `en`=0 cycles change nothing.
- Assert `reset` for 1 cycle after sync plus 4 payload bits, then send a full good 8'h3C frame → no strobe for the aborted frame, one strobe for 8'h3C, `frame_cnt`=1.
- 256 consecutive good frames → `frame_cnt` goes 255 then 0; the 257th good frame gives 1.
